write_data_select: RTL
======================

WRITE_DATA_SELECT -- requirements
Module: write_data_select

Interface
REQ-001 Parameter: DATA_W, default 32, width of every source word and of the output word.
REQ-002 Parameter: NUM_SRC, default 10, number of selectable sources; legal range 2..16.
REQ-003 Parameter: SEL_W, default 4, width of sel; the instantiator SHALL set it so that 2**SEL_W >= NUM_SRC.
REQ-004 Port: clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 Port: reset_n, input, 1 bit, synchronous active-low reset.
REQ-006 Port: src_data, input, NUM_SRC*DATA_W bits, flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-007 Port: sel, input, SEL_W bits, source index.
REQ-008 Port: ext_mode, input, 2 bits: 00 pass, 01 byte extend, 10 half extend, 11 shift-left-16.
REQ-009 Port: in_valid, input, 1 bit, producer offers sel/ext_mode/src_data this cycle.
REQ-010 Port: in_ready, output, 1 bit, block can accept this cycle.
REQ-011 Port: out_data, output, DATA_W bits, registered write data to the register file.
REQ-012 Port: out_valid, output, 1 bit, out_data holds an unconsumed word.
REQ-013 Port: out_ready, input, 1 bit, register file consumes out_data this cycle.
REQ-014 Port: sel_err, output, 1 bit, sticky flag for an out-of-range sel accepted.

Function
REQ-015 Accept: an accept occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-016 Consume: a consume occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL be combinationally (!out_valid || out_ready); single-entry output stage, no skid buffer.
REQ-018 On accept, out_data SHALL load f(ext_mode, src_data[sel]) and out_valid SHALL be 1 from the next cycle; latency is exactly 1 cycle.
REQ-019 Mode 00: out_data = source word unchanged.
REQ-020 Mode 01: out_data = source bits [7:0] extended to DATA_W (extension kind per REQ-031/032).
REQ-021 Mode 10: out_data = source bits [15:0] extended to DATA_W (extension kind per REQ-031/032).
REQ-022 Mode 11: out_data = source bits [DATA_W-17:0] shifted left by 16, low 16 bits zero.
REQ-023 sel >= NUM_SRC on accept: out_data SHALL load all-zero regardless of ext_mode, and sel_err SHALL set; the transfer still completes normally.
REQ-024 sel_err SHALL stay 1 until reset; no other clear.
REQ-025 A consume without a simultaneous accept SHALL clear out_valid on the next cycle.
REQ-026 A simultaneous accept and consume SHALL keep out_valid=1 and load the new word; no bubble.
REQ-027 While out_valid=1 and out_ready=0, out_data SHALL hold its value and in_ready SHALL be 0.
REQ-028 When in_valid=0, sel, ext_mode and src_data are don't-care and SHALL NOT affect any state.

Reset
REQ-029 When reset_n=0 at a rising edge, out_valid<=0, out_data<=0 and sel_err<=0; reset takes priority over any accept or consume in that cycle.
REQ-030 Reset mid-transfer drops the held word, and in_ready SHALL read 1 in the cycle after reset is released.

Configuration
REQ-031 With macro WDSEL_SIGN_EXT_EN defined, modes 01 and 10 SHALL sign-extend from bit 7 and bit 15 respectively.
REQ-032 Without WDSEL_SIGN_EXT_EN, modes 01 and 10 SHALL zero-extend; all other behaviour SHALL be identical.

Verification
REQ-033 Scenario, basic select: reset; sel=3, mode 00, src3=0xDEADBEEF, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF.
REQ-034 Scenario, byte extend: sel=0, mode 01, src0=0x000000F3 -> out_data=0xFFFFFFF3 with the macro defined, 0x000000F3 without it.
REQ-035 Scenario, shift-left-16: sel=8, mode 11, src8=0x00001234 -> out_data=0x12340000.
REQ-036 Scenario, backpressure: out_ready=0 after an accept of 0x11111111 -> in_ready=0 and out_data stays 0x11111111 for 5 cycles while in_valid=1 with other data; out_ready=1 -> the pending word is consumed and the next word is accepted in the same edge.
REQ-037 Scenario, illegal sel: NUM_SRC=10, sel=12, in_valid=1 -> out_data=0, out_valid=1, sel_err=1, and sel_err stays 1 through 20 legal transfers.
REQ-038 Scenario, reset mid-transfer: out_valid=1, out_ready=0, reset_n=0 for one edge -> out_valid=0, out_data=0, sel_err=0, and in_ready=1 in the next cycle.

Source files
------------

// File: rtl/write_data_select.sv
// write_data_select: picks one of NUM_SRC source words, applies the requested
// extension/shift and presents it through a single-entry valid/ready output
// register toward the register file.
// Build option: define WDSEL_SIGN_EXT_EN to make the byte/half modes
// sign-extend; without it they zero-extend.
module write_data_select #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 10,
    parameter int SEL_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                ext_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    // Source table padded to every sel code so any index is in range;
    // padding entries read as zero and are flagged illegal.
    localparam int DEPTH = 1 << SEL_W;

    logic [DATA_W-1:0] src_words [DEPTH];
    logic [DEPTH-1:0]  sel_legal;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_real
                assign src_words[gi] = src_data[gi*DATA_W +: DATA_W];
                assign sel_legal[gi] = 1'b1;
            end else begin : g_pad
                assign src_words[gi] = '0;
                assign sel_legal[gi] = 1'b0;
            end
        end
    endgenerate

    logic [DATA_W-1:0] word_sel;
    logic              sel_ok;
    logic              byte_sign;
    logic              half_sign;
    logic [DATA_W-1:0] data_next;
    logic              accept;
    logic              consume;

    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              sel_err_reg;

    assign word_sel = src_words[sel];
    assign sel_ok   = sel_legal[sel];

`ifdef WDSEL_SIGN_EXT_EN
    assign byte_sign = word_sel[7];
    assign half_sign = word_sel[15];
`else
    assign byte_sign = 1'b0;
    assign half_sign = 1'b0;
`endif

    // Single-entry stage: room exists when empty or when the held word leaves now.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;

    // Format the selected word; an illegal index always yields zero.
    always_comb begin
        data_next = '0;
        if (sel_ok) begin
            case (ext_mode)
                2'b00:   data_next = word_sel;
                2'b01:   data_next = {{(DATA_W-8){byte_sign}}, word_sel[7:0]};
                2'b10:   data_next = {{(DATA_W-16){half_sign}}, word_sel[15:0]};
                default: data_next = {word_sel[DATA_W-17:0], 16'h0000};
            endcase
        end
    end

    // Output register: load on accept, drain on consume, sticky illegal-sel flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                out_data_reg  <= data_next;
                out_valid_reg <= 1'b1;
                if (!sel_ok) begin
                    sel_err_reg <= 1'b1;
                end
            end else if (consume) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign sel_err   = sel_err_reg;

endmodule
